// File: rtl/mem_stage.sv
// Memory-access stage after the ALU. It does load/store over req/ack with byte-lane steering, load extension and an optional alignment check (MEM_STAGE_ALIGN_CHECK_EN).
// Latency: NONE, overflow and misaligned ops retire 1 cycle after accept. Memory ops retire 1 cycle after the cycle in which dmem_ack is sampled.
// Backpressure: ex_ready is low for the whole time a memory transaction is outstanding (REQ state).
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_alu_out,
    input  logic        ex_overflow,
    input  logic [3:0]  ex_mem_op,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [1:0]  wb_exc,
    output logic [31:0] wb_badaddr
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_OVF  = 2'd1;
    localparam logic [1:0] EXC_ADEL = 2'd2;
    localparam logic [1:0] EXC_ADES = 2'd3;

    logic [0:0]  state;
    logic [3:0]  req_op;
    logic [1:0]  req_lane;
    logic [4:0]  req_rd;
    logic        req_reg_write;

    logic        is_load;
    logic        is_store;
    logic        misalign;
    logic [31:0] badaddr_next;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    // Only IDLE can accept; REQ stalls execute until the ack arrives.
    assign ex_ready = (state == IDLE);

    // Decode the incoming op: class, alignment fault, lane enables and replicated store data.
    always_comb begin
        is_load      = (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_LW);
        is_store     = (ex_mem_op >= OP_SB) && (ex_mem_op <= OP_SW);
        misalign     = 1'b0;
        badaddr_next = '0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        if ((ex_mem_op == OP_LH) || (ex_mem_op == OP_LHU) || (ex_mem_op == OP_SH))
            misalign = ex_alu_out[0];
        else if ((ex_mem_op == OP_LW) || (ex_mem_op == OP_SW))
            misalign = |ex_alu_out[1:0];
        badaddr_next = ex_alu_out;
`endif
        be_next    = 4'b1111;
        wdata_next = ex_store_data;
        case (ex_mem_op)
            OP_SB: begin
                be_next    = 4'b0001 << ex_alu_out[1:0];
                wdata_next = {4{ex_store_data[7:0]}};
            end
            OP_SH: begin
                be_next    = ex_alu_out[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed lane of the returned word and sign/zero-extend it for the latched load type.
    always_comb begin
        case (req_lane)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = req_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (req_op)
            OP_LB:   ld_value = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_value = {24'd0, ld_byte};
            OP_LH:   ld_value = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_value = {16'd0, ld_half};
            default: ld_value = dmem_rdata;
        endcase
    end

    // State machine plus every registered output. wb_* only change on the cycle they pulse valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            req_op        <= '0;
            req_lane      <= '0;
            req_rd        <= '0;
            req_reg_write <= 1'b0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_be       <= '0;
            dmem_wdata    <= '0;
            wb_valid      <= 1'b0;
            wb_data       <= '0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
            wb_exc        <= EXC_NONE;
            wb_badaddr    <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (ex_overflow || !(is_load || is_store)) begin
                            // Overflow outranks any memory op: no request, retire right away.
                            wb_valid     <= 1'b1;
                            wb_data      <= ex_alu_out;
                            wb_rd        <= ex_rd;
                            wb_reg_write <= ex_reg_write & ~ex_overflow;
                            wb_exc       <= ex_overflow ? EXC_OVF : EXC_NONE;
                            wb_badaddr   <= '0;
                        end else if (misalign) begin
                            wb_valid     <= 1'b1;
                            wb_data      <= '0;
                            wb_rd        <= ex_rd;
                            wb_reg_write <= 1'b0;
                            wb_exc       <= is_store ? EXC_ADES : EXC_ADEL;
                            wb_badaddr   <= badaddr_next;
                        end else begin
                            state         <= REQ;
                            dmem_req      <= 1'b1;
                            dmem_we       <= is_store;
                            dmem_addr     <= {ex_alu_out[31:2], 2'b00};
                            dmem_be       <= be_next;
                            dmem_wdata    <= wdata_next;
                            req_op        <= ex_mem_op;
                            req_lane      <= ex_alu_out[1:0];
                            req_rd        <= ex_rd;
                            req_reg_write <= ex_reg_write;
                        end
                    end
                end
                REQ: begin
                    // Request fields stay frozen until the ack is seen.
                    if (dmem_ack) begin
                        state        <= IDLE;
                        dmem_req     <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_data      <= dmem_we ? 32'd0 : ld_value;
                        wb_rd        <= req_rd;
                        wb_reg_write <= ~dmem_we & req_reg_write;
                        wb_exc       <= EXC_NONE;
                        wb_badaddr   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table plus hand-written corner sequences.
// Latency: expected retire cycle is carried in each scoreboard entry.
// Backpressure: ex_ready is checked during and just after each memory transaction.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_alu_out = '0;
    logic        ex_overflow = 1'b0;
    logic [3:0]  ex_mem_op = '0;
    logic [31:0] ex_store_data = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_write = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [1:0]  wb_exc;
    logic [31:0] wb_badaddr;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_out(ex_alu_out), .ex_overflow(ex_overflow), .ex_mem_op(ex_mem_op),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_exc(wb_exc), .wb_badaddr(wb_badaddr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  exc;
        logic [31:0] bad;
        int          cyc;
    } sb_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] alu;
        logic        ovf;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] rdata;
        int          delay;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        logic        chk_data;
        logic        exp_rw;
        logic [1:0]  exp_exc;
        logic [31:0] exp_bad;
    } vec_t;

    sb_t  sbq[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(
        input logic [3:0] op, input logic [31:0] alu, input logic ovf, input logic [31:0] sdata,
        input logic rw, input logic [31:0] rdata, input int delay, input logic exp_req,
        input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
        input logic [31:0] exp_data, input logic chk_data, input logic exp_rw,
        input logic [1:0] exp_exc, input logic [31:0] exp_bad);
        vec_t v;
        v.op = op; v.alu = alu; v.ovf = ovf; v.sdata = sdata; v.rd = 5'd0; v.rw = rw;
        v.rdata = rdata; v.delay = delay; v.exp_req = exp_req; v.exp_addr = exp_addr;
        v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_data = exp_data;
        v.chk_data = chk_data; v.exp_rw = exp_rw; v.exp_exc = exp_exc; v.exp_bad = exp_bad;
        return v;
    endfunction

    // Scoreboard consumer: every wb_valid pulse must match the oldest expected retirement.
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                check("wb_valid_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                check("wb_cycle", cyc, e.cyc);
                check("wb_rd", 32'(wb_rd), 32'(e.rd));
                check("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
                check("wb_exc", 32'(wb_exc), 32'(e.exc));
                check("wb_badaddr", wb_badaddr, e.bad);
                if (e.chk_data) check("wb_data", wb_data, e.data);
            end
        end
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] alu, input logic ovf,
                         input logic [31:0] sdata, input logic [4:0] rd, input logic rw);
        ex_valid = 1'b1; ex_mem_op = op; ex_alu_out = alu; ex_overflow = ovf;
        ex_store_data = sdata; ex_rd = rd; ex_reg_write = rw;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_mem_op = 4'd0; ex_overflow = 1'b0; ex_reg_write = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] data, input logic chk_data, input logic [4:0] rd,
                            input logic rw, input logic [1:0] exc, input logic [31:0] bad, input int c);
        sb_t e;
        e.data = data; e.chk_data = chk_data; e.rd = rd; e.rw = rw; e.exc = exc; e.bad = bad; e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && sbq.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        check(name, sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int acc;
        logic st;
        st = (v.op >= 4'd6) && (v.op <= 4'd8);
        @(posedge clk); #1;
        check({name, ":ex_ready_idle"}, 32'(ex_ready), 32'd1);
        drive(v.op, v.alu, v.ovf, v.sdata, v.rd, v.rw);
        acc = cyc;
        push_exp(v.exp_data, v.chk_data, v.rd, v.exp_rw, v.exp_exc, v.exp_bad,
                 v.exp_req ? acc + 2 + v.delay : acc + 1);
        @(posedge clk); #1;
        idle_inputs();
        if (v.exp_req) begin
            for (int i = 0; i <= v.delay; i++) begin
                if (i == v.delay) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = v.rdata;
                end
                @(negedge clk);
                check({name, ":dmem_req"}, 32'(dmem_req), 32'd1);
                check({name, ":dmem_we"}, 32'(dmem_we), 32'(st));
                check({name, ":dmem_addr"}, dmem_addr, v.exp_addr);
                check({name, ":dmem_be"}, 32'(dmem_be), 32'(v.exp_be));
                if (st) check({name, ":dmem_wdata"}, dmem_wdata, v.exp_wdata);
                check({name, ":ex_ready_busy"}, 32'(ex_ready), 32'd0);
                @(posedge clk); #1;
            end
            dmem_ack = 1'b0;
            dmem_rdata = 32'h0;
            check({name, ":ex_ready_after_ack"}, 32'(ex_ready), 32'd1);
            @(negedge clk);
            check({name, ":dmem_req_dropped"}, 32'(dmem_req), 32'd0);
        end else begin
            @(negedge clk);
            check({name, ":no_dmem_req"}, 32'(dmem_req), 32'd0);
        end
        drain({name, ":retired"});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        int acc;

        // op, alu, ovf, sdata, rw, rdata, delay, req, addr, be, wdata, data, chk, rw_exp, exc, bad
        vecs.push_back(mk(4'd0, 32'h1234_5678, 1'b0, 32'h0, 1'b1, 32'h0, 0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h1234_5678, 1'b1, 1'b1, 2'd0, 32'h0));
        vecs.push_back(mk(4'd12, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1, 32'h0, 0, 1'b0, 32'h0, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b1, 2'd0, 32'h0));
        vecs.push_back(mk(4'd0, 32'h7FFF_FFFF, 1'b1, 32'h0, 1'b1, 32'h0, 0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h7FFF_FFFF, 1'b1, 1'b0, 2'd1, 32'h0));
        vecs.push_back(mk(4'd5, 32'h0000_4000, 1'b1, 32'h0, 1'b1, 32'h0, 0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd1, 32'h0));
        vecs.push_back(mk(4'd6, 32'h0000_1003, 1'b0, 32'h1234_56AB, 1'b1, 32'h0, 3, 1'b1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0));
        vecs.push_back(mk(4'd1, 32'h0000_2002, 1'b0, 32'h0, 1'b1, 32'h8F80_1234, 0, 1'b1, 32'h0000_2000, 4'b1111, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b1, 2'd0, 32'h0));
        vecs.push_back(mk(4'd2, 32'h0000_2002, 1'b0, 32'h0, 1'b1, 32'h8F80_1234, 0, 1'b1, 32'h0000_2000, 4'b1111, 32'h0, 32'h0000_0080, 1'b1, 1'b1, 2'd0, 32'h0));
        vecs.push_back(mk(4'd3, 32'h0000_2002, 1'b0, 32'h0, 1'b1, 32'h8F80_1234, 0, 1'b1, 32'h0000_2000, 4'b1111, 32'h0, 32'hFFFF_8F80, 1'b1, 1'b1, 2'd0, 32'h0));
        vecs.push_back(mk(4'd4, 32'h0000_2000, 1'b0, 32'h0, 1'b1, 32'h8F80_F234, 1, 1'b1, 32'h0000_2000, 4'b1111, 32'h0, 32'h0000_F234, 1'b1, 1'b1, 2'd0, 32'h0));
        vecs.push_back(mk(4'd7, 32'h0000_2002, 1'b0, 32'h0000_BEEF, 1'b1, 32'h0, 1, 1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0));
        vecs.push_back(mk(4'd8, 32'h0000_5004, 1'b0, 32'hCAFE_F00D, 1'b1, 32'h0, 2, 1'b1, 32'h0000_5004, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0));
        vecs.push_back(mk(4'd5, 32'h0000_5008, 1'b0, 32'h0, 1'b1, 32'hA5A5_0001, 1, 1'b1, 32'h0000_5008, 4'b1111, 32'h0, 32'hA5A5_0001, 1'b1, 1'b1, 2'd0, 32'h0));
        vecs.push_back(mk(4'd1, 32'h0000_6001, 1'b0, 32'h0, 1'b1, 32'h0000_7F00, 0, 1'b1, 32'h0000_6000, 4'b1111, 32'h0, 32'h0000_007F, 1'b1, 1'b1, 2'd0, 32'h0));
        vecs.push_back(mk(4'd1, 32'h0000_7003, 1'b0, 32'h0, 1'b0, 32'h8000_0000, 0, 1'b1, 32'h0000_7000, 4'b1111, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b0, 2'd0, 32'h0));
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        vecs.push_back(mk(4'd5, 32'h0000_3001, 1'b0, 32'h0, 1'b1, 32'h0, 0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd2, 32'h0000_3001));
        vecs.push_back(mk(4'd7, 32'h0000_3001, 1'b0, 32'h1234, 1'b1, 32'h0, 0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd3, 32'h0000_3001));
`else
        vecs.push_back(mk(4'd5, 32'h0000_3001, 1'b0, 32'h0, 1'b1, 32'h1111_2222, 0, 1'b1, 32'h0000_3000, 4'b1111, 32'h0, 32'h1111_2222, 1'b1, 1'b1, 2'd0, 32'h0));
        vecs.push_back(mk(4'd7, 32'h0000_3001, 1'b0, 32'h1234, 1'b1, 32'h0, 0, 1'b1, 32'h0000_3000, 4'b0011, 32'h1234_1234, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0));
`endif

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst:ex_ready", 32'(ex_ready), 32'd1);
        check("rst:dmem_req", 32'(dmem_req), 32'd0);
        check("rst:dmem_we", 32'(dmem_we), 32'd0);
        check("rst:dmem_addr", dmem_addr, 32'd0);
        check("rst:dmem_be", 32'(dmem_be), 32'd0);
        check("rst:dmem_wdata", dmem_wdata, 32'd0);
        check("rst:wb_valid", 32'(wb_valid), 32'd0);
        check("rst:wb_data", wb_data, 32'd0);
        check("rst:wb_rd", 32'(wb_rd), 32'd0);
        check("rst:wb_reg_write", 32'(wb_reg_write), 32'd0);
        check("rst:wb_exc", 32'(wb_exc), 32'd0);
        check("rst:wb_badaddr", wb_badaddr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table of single instructions.
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            v.rd = 5'(i + 3);
            run_vec(v, $sformatf("vec%0d", i));
        end

        // Back-to-back NONE ops, last one overflows: retire on consecutive cycles.
        @(posedge clk); #1;
        drive(4'd0, 32'h11, 1'b0, 32'h0, 5'd1, 1'b1);
        acc = cyc;
        push_exp(32'h11, 1'b1, 5'd1, 1'b1, 2'd0, 32'h0, acc + 1);
        @(posedge clk); #1;
        check("b2b:ex_ready1", 32'(ex_ready), 32'd1);
        drive(4'd0, 32'h22, 1'b0, 32'h0, 5'd2, 1'b1);
        push_exp(32'h22, 1'b1, 5'd2, 1'b1, 2'd0, 32'h0, acc + 2);
        @(posedge clk); #1;
        check("b2b:ex_ready2", 32'(ex_ready), 32'd1);
        drive(4'd0, 32'h33, 1'b1, 32'h0, 5'd3, 1'b1);
        push_exp(32'h33, 1'b1, 5'd3, 1'b0, 2'd1, 32'h0, acc + 3);
        @(posedge clk); #1;
        idle_inputs();
        drain("b2b:retired");

        // Ack while idle must be ignored.
        @(posedge clk); #1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        check("idle_ack:wb_valid", 32'(wb_valid), 32'd0);
        check("idle_ack:dmem_req", 32'(dmem_req), 32'd0);
        check("idle_ack:ex_ready", 32'(ex_ready), 32'd1);

        // Reset in the second REQ cycle with the ack withheld drops the load.
        @(posedge clk); #1;
        drive(4'd5, 32'h0000_8000, 1'b0, 32'h0, 5'd9, 1'b1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("rst_req:dmem_req_c1", 32'(dmem_req), 32'd1);
        @(posedge clk); #1;
        check("rst_req:ex_ready_c2", 32'(ex_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_req:dmem_req", 32'(dmem_req), 32'd0);
        check("rst_req:ex_ready", 32'(ex_ready), 32'd1);
        check("rst_req:wb_valid", 32'(wb_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_req:wb_valid_later", 32'(wb_valid), 32'd0);
        end

        // Stage works again after the abandoned request.
        run_vec(vecs[0], "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
